act_stream: RTL
===============

# act_stream

Parametrised, pipelined activation unit: successor to the 4-bit combinational ReLU. Applies a selectable activation (bypass, ReLU, leaky ReLU, clamped ReLU) to LANES signed two's-complement lanes per beat, behind a valid/ready streaming handshake. It sits between the accumulator output and the next layer's input buffer, and keeps a saturating count of rectified negative lanes for debug and sparsity statistics.

## Interface
- WIDTH, 8: bits per lane, signed two's complement; legal range 2..32.
- LANES, 4: lanes per beat.
- LEAK_SHIFT, 3: leaky-mode arithmetic right-shift amount; legal range 1..WIDTH-1.
- CNT_W, 16: width of the negative-lane counter.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_vld  in  1  input beat valid.
- in_rdy  out  1  unit can accept a beat this cycle.
- in_data  in  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH].
- mode  in  2  activation for this beat: 00 bypass, 01 ReLU, 10 leaky, 11 clamp. Sampled with the beat.
- cap  in  WIDTH-1  unsigned clamp ceiling for mode 11. Sampled with the beat.
- out_vld  out  1  output beat valid.
- out_rdy  in  1  downstream accepts a beat.
- out_data  out  LANES*WIDTH  activated lanes, same packing as in_data.
- clr_cnt  in  1  synchronous clear of neg_cnt.
- neg_cnt  out  CNT_W  saturating count of negative lanes rectified.

## Operation
- Per-lane function, x signed:
  - bypass: y = x.
  - ReLU: y = (x<0) ? 0 : x.
  - leaky: y = (x<0) ? x>>>LEAK_SHIFT : x. Arithmetic shift, rounds toward -inf, so -1 maps to -1.
  - clamp: y = (x<0) ? 0 : min(x, {1'b0,cap}).
- Lanes are independent. Output width equals input width, so no result can overflow.
- A handshake occurs when vld && rdy in the same cycle. Data, mode and cap are captured only on handshake.
- neg_cnt increments by the number of lanes with MSB=1 in each accepted beat whose mode != bypass.
  - Saturates at 2^CNT_W-1. No wrap.
  - clr_cnt has priority over a same-cycle increment: the count becomes 0 and that beat's contribution is lost.
- Reset mid-stream flushes both stages. In-flight beats are dropped and never presented.

## Timing
- Two register stages: S1 holds the captured beat, mode and cap; S2 holds the result. The lane function sits between S1 and S2.
- Latency: a beat accepted in cycle N appears on out_data with out_vld=1 in cycle N+2, provided out_rdy is held at 1.
- Throughput: 1 beat/cycle while out_rdy=1.
- Stall logic:
  - s2_adv = !s2_vld || out_rdy
  - s1_adv = !s1_vld || s2_adv
  - in_rdy = s1_adv (combinational; no combinational path from in_vld to in_rdy).
- While out_vld=1 and out_rdy=0, out_data is held stable. No beat is lost or duplicated under any out_rdy pattern.
- Reset values: out_vld=0, out_data=0, neg_cnt=0, S1/S2 valid=0. in_rdy=1 from the first cycle after reset release.
- neg_cnt updates in the cycle after input acceptance; it is counted at S1 capture.

## Structure
- Package act_pkg:
  - typedef enum logic [1:0] act_mode_t {ACT_BYPASS, ACT_RELU, ACT_LEAKY, ACT_CLAMP}.
  - Default parameter constants.
- Sub-module act_lane: purely combinational, one lane. Ports x, mode, cap, y, and is_neg. Instantiated LANES times by generate loop between S1 and S2.
- Top level act_stream holds the S1/S2 registers, handshake logic, and popcount/saturating counter.

## Test plan
- Legacy equivalence, WIDTH=4, LANES=1, mode=ReLU, out_rdy=1: inputs 0000, 0101, 1001, 1111, 0001 -> outputs 0000, 0101, 0000, 0000, 0001 in order, each 2 cycles after acceptance.
- Defaults, leaky mode: lanes {-8, -1, 0, 127} -> {-1, -1, 0, 127}. Bypass with {-128, 5, -3, 64} -> unchanged; neg_cnt unchanged.
- Clamp mode, cap=20: lanes {-5, 19, 20, 100} -> {0, 19, 20, 20}. Clamp mode, cap=0: lanes {-5, 19, 20, 100} -> all 0.
- Backpressure: stream 10 incrementing beats with out_rdy toggling 1,0,0,1,…
  - Outputs appear in order with no drop or duplicate.
  - out_data is stable while stalled.
  - in_rdy=0 exactly when both stages are full and out_rdy=0.
- Counter, CNT_W=4, ReLU, all lanes negative:
  - 4 beats -> neg_cnt=15 (saturated), not 0.
  - clr_cnt asserted with a 5th beat -> neg_cnt=0.
- Reset mid-operation: drop rst_n with S1 and S2 full -> out_vld=0, out_data=0, neg_cnt=0 immediately (asynchronously). After release, no stale beat appears and in_rdy=1.

Source files
------------

// File: rtl/act_pkg.sv
// Shared types and default parameters for the act_stream activation pipeline.
package act_pkg;

    typedef enum logic [1:0] {
        ACT_BYPASS = 2'b00,
        ACT_RELU   = 2'b01,
        ACT_LEAKY  = 2'b10,
        ACT_CLAMP  = 2'b11
    } act_mode_t;

    localparam int ACT_WIDTH      = 32'sd8;
    localparam int ACT_LANES      = 32'sd4;
    localparam int ACT_LEAK_SHIFT = 32'sd3;
    localparam int ACT_CNT_W      = 32'sd16;

    // Bits needed to hold any count from 0 to n inclusive.
    function automatic int cnt_bits(input int n);
        int b;
        if (n < 32'sd1) begin
            b = 32'sd1;
        end else begin
            b = $clog2(n + 32'sd1);
        end
        return b;
    endfunction

endpackage

// File: rtl/act_stream_if.sv
// Streaming port bundle of act_stream: input beat channel, output beat channel and debug counter.
interface act_stream_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int CNT_W = 16
);
    import act_pkg::*;

    logic                   in_vld;
    logic                   in_rdy;
    logic [LANES*WIDTH-1:0] in_data;
    act_mode_t              mode;
    logic [WIDTH-2:0]       cap;
    logic                   out_vld;
    logic                   out_rdy;
    logic [LANES*WIDTH-1:0] out_data;
    logic                   clr_cnt;
    logic [CNT_W-1:0]       neg_cnt;

    modport master (
        output in_vld, in_data, mode, cap, out_rdy, clr_cnt,
        input  in_rdy, out_vld, out_data, neg_cnt
    );

    modport slave (
        input  in_vld, in_data, mode, cap, out_rdy, clr_cnt,
        output in_rdy, out_vld, out_data, neg_cnt
    );

endinterface

// File: rtl/act_lane.sv
// One signed lane of the activation function; purely combinational.
module act_lane
    import act_pkg::*;
#(
    parameter int WIDTH      = ACT_WIDTH,
    parameter int LEAK_SHIFT = ACT_LEAK_SHIFT
) (
    input  logic signed [WIDTH-1:0] x,
    input  act_mode_t               mode,
    input  logic        [WIDTH-2:0] cap,
    output logic signed [WIDTH-1:0] y,
    output logic                    is_neg
);

    logic signed [WIDTH-1:0] leak_s;
    logic signed [WIDTH-1:0] cap_s;

    assign is_neg = x[WIDTH-1];
    // Arithmetic shift floors toward -inf, so small negatives settle at -1 rather than 0.
    assign leak_s = x >>> LEAK_SHIFT;
    assign cap_s  = $signed({1'b0, cap});

    // Lane result selection by activation mode.
    always_comb begin
        y = x;
        case (mode)
            ACT_BYPASS: begin
                y = x;
            end
            ACT_RELU: begin
                if (is_neg) begin
                    y = {WIDTH{1'b0}};
                end else begin
                    y = x;
                end
            end
            ACT_LEAKY: begin
                if (is_neg) begin
                    y = leak_s;
                end else begin
                    y = x;
                end
            end
            ACT_CLAMP: begin
                if (is_neg) begin
                    y = {WIDTH{1'b0}};
                end else if (x > cap_s) begin
                    y = cap_s;
                end else begin
                    y = x;
                end
            end
            default: begin
                y = x;
            end
        endcase
    end

endmodule

// File: rtl/act_stream.sv
// Two-stage valid/ready activation pipeline over LANES signed lanes, with a
// saturating count of negative lanes seen in rectifying modes.
module act_stream
    import act_pkg::*;
#(
    parameter int WIDTH      = ACT_WIDTH,
    parameter int LANES      = ACT_LANES,
    parameter int LEAK_SHIFT = ACT_LEAK_SHIFT,
    parameter int CNT_W      = ACT_CNT_W
) (
    input logic         clk,
    input logic         rst_n,
    act_stream_if.slave io
);

    localparam int               INC_W   = cnt_bits(LANES);
    localparam int               SUM_W   = CNT_W + INC_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic                   s1_vld_r;
    logic [LANES*WIDTH-1:0] s1_data_r;
    act_mode_t              s1_mode_r;
    logic [WIDTH-2:0]       s1_cap_r;
    logic                   s2_vld_r;
    logic [LANES*WIDTH-1:0] s2_data_r;
    logic [CNT_W-1:0]       cnt_r;

    logic                   s1_adv_s;
    logic                   s2_adv_s;
    logic                   in_hs_s;
    logic [LANES*WIDTH-1:0] lane_y_s;
    // The S1 sign flags are not needed: negatives are counted at capture time.
    logic [LANES-1:0]       lane_neg_unused_s;
    logic [INC_W-1:0]       inc_s;
    logic [SUM_W-1:0]       sum_s;
    logic [CNT_W-1:0]       cnt_nxt_s;

    function automatic logic [INC_W-1:0] neg_lanes(input logic [LANES*WIDTH-1:0] d);
        logic [INC_W-1:0] n;
        n = {INC_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            n = n + INC_W'(d[i*WIDTH + WIDTH - 1]);
        end
        return n;
    endfunction

    // A stage may load when it is empty or its content leaves this cycle.
    assign s2_adv_s  = !s2_vld_r || io.out_rdy;
    assign s1_adv_s  = !s1_vld_r || s2_adv_s;
    assign in_hs_s   = io.in_vld && s1_adv_s;
    assign io.in_rdy = s1_adv_s;

    // S1 register: captures beat, mode and cap on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_r  <= 1'b0;
            s1_data_r <= {(LANES*WIDTH){1'b0}};
            s1_mode_r <= ACT_BYPASS;
            s1_cap_r  <= {(WIDTH-1){1'b0}};
        end else if (s1_adv_s) begin
            s1_vld_r <= io.in_vld;
            if (io.in_vld) begin
                s1_data_r <= io.in_data;
                s1_mode_r <= io.mode;
                s1_cap_r  <= io.cap;
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        act_lane #(
            .WIDTH      (WIDTH),
            .LEAK_SHIFT (LEAK_SHIFT)
        ) u_lane (
            .x      (s1_data_r[g*WIDTH +: WIDTH]),
            .mode   (s1_mode_r),
            .cap    (s1_cap_r),
            .y      (lane_y_s[g*WIDTH +: WIDTH]),
            .is_neg (lane_neg_unused_s[g])
        );
    end

    // S2 register: holds the activated beat until downstream takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_r  <= 1'b0;
            s2_data_r <= {(LANES*WIDTH){1'b0}};
        end else if (s2_adv_s) begin
            s2_vld_r <= s1_vld_r;
            if (s1_vld_r) begin
                s2_data_r <= lane_y_s;
            end
        end
    end

    assign io.out_vld  = s2_vld_r;
    assign io.out_data = s2_data_r;

    // Next count: clear wins, otherwise add this beat's negatives and saturate.
    always_comb begin
        inc_s     = {INC_W{1'b0}};
        sum_s     = {SUM_W{1'b0}};
        cnt_nxt_s = cnt_r;
        if (in_hs_s && (io.mode != ACT_BYPASS)) begin
            inc_s = neg_lanes(io.in_data);
        end else begin
            inc_s = {INC_W{1'b0}};
        end
        sum_s = SUM_W'(cnt_r) + SUM_W'(inc_s);
        if (io.clr_cnt) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (sum_s > SUM_W'(CNT_MAX)) begin
            cnt_nxt_s = CNT_MAX;
        end else begin
            cnt_nxt_s = sum_s[CNT_W-1:0];
        end
    end

    // Negative-lane counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign io.neg_cnt = cnt_r;

endmodule
